mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares the data memory's single fetch port and single write port between NUM_REQ requesters.
// - Requester 0 is the CPU load/store unit; requester 1 is the program loader/debug port.
// - Sits between the requesters and the memory block; forwards one transaction at a time.
// - Round-robin arbitration; the grant is held for the whole transaction (write handshake included).
// PARAMETERS
// - ADDR_WIDTH  32  byte address width; matches the memory block.
// - DATA_WIDTH  32  data word width; DATA_BYTE_SIZE = DATA_WIDTH/8.
// - NUM_REQ     2   number of requesters; must be >= 2.
// PORTS
// - clk                  in   1                      single clock, rising edge
// - rst_n                in   1                      reset: asynchronous, active-low
// - req_valid            in   NUM_REQ                per-requester request; held until its rsp_valid
// - req_we               in   NUM_REQ                1 = write, 0 = read (fetch)
// - req_addr             in   NUM_REQ x ADDR_WIDTH   byte address
// - req_wdata            in   NUM_REQ x DATA_WIDTH   write data, byte 0 in bits [7:0]
// - req_bytes            in   NUM_REQ x (log2(DATA_BYTE_SIZE)+1)   write byte count, 0..DATA_BYTE_SIZE
// - rsp_valid            out  NUM_REQ                one-cycle completion pulse, one-hot or zero
// - rsp_rdata            out  DATA_WIDTH             read data; valid while any rsp_valid bit is set for a read
// - mem_fetch_addr       out  ADDR_WIDTH             to memory fetch_addr
// - mem_fetched_data     in   DATA_WIDTH             from memory fetched_data
// - mem_fetch_done       in   1                      from memory fetch_done
// - mem_write_addr       out  ADDR_WIDTH             to memory write_addr
// - mem_write_data       out  DATA_WIDTH             to memory write_data
// - mem_bytes_to_write   out  log2(DATA_BYTE_SIZE)+1 to memory bytes_to_write
// - mem_write_data_valid out  1                      to memory write_data_valid
// - mem_write_done       in   1                      from memory; write commits at the next posedge
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE, rr_ptr=0; all outputs 0. mem_write_data_valid drops immediately. A transaction in flight is abandoned and produces no rsp_valid.
// - States: IDLE, READ, WRITE, RESP.
// - IDLE: grant = first req_valid bit at or after rr_ptr, searching upward with wrap. Latch the grant index and the requester's we/addr/wdata/bytes into internal registers. Go to WRITE if we=1, else READ. If there is no request, stay in IDLE.
// - After a grant, rr_ptr = (grant+1) mod NUM_REQ.
// - READ: mem_fetch_addr = latched addr. On mem_fetch_done=1, capture mem_fetched_data into rsp_rdata and go to RESP. Otherwise stay in READ.
// - WRITE: mem_write_data_valid=1; mem_write_addr/data/bytes = latched values. On mem_write_done=1 (the memory commits at this edge), deassert valid and go to RESP.
// - RESP: rsp_valid[grant]=1 for exactly one cycle, then IDLE.
// - Minimum latency, req_valid to rsp_valid: read = 3 cycles (IDLE->READ->RESP); write = 3 cycles plus wait cycles on write_done.
// - After RESP, the requester must drop req_valid or present a new request. A request still asserted is treated as a new one on the following IDLE cycle.
// - Memory outputs hold their latched values outside their active state. Only the valid strobe gates them.
// - req_bytes=0 write: still issued and completed; the memory writes no bytes.
// - req_bytes > DATA_BYTE_SIZE: passed through unchanged; no error flag.
// - Changing req_* while waiting for a grant is legal. Changing them after the grant has no effect, because the values are latched.
// - rsp_rdata holds its last read value until the next read completes.
// - No pipelining: at most one outstanding transaction.
// STRUCTURE
// - Shared package mem_pkg: arb_state_e enum {IDLE,READ,WRITE,RESP}.
// - mem_pkg also holds the DATA_BYTE_SIZE / byte-count width localparams, shared with the memory block.
// - Sub-module rr_arbiter (NUM_REQ): combinational round-robin pick from req vector + rr_ptr, gives a one-hot grant and its index.
// - FSM, latch registers and pointer update stay in mem_port_arbiter.
// TESTING
// - Reset, then req_valid=2'b01 read addr 0x10, memory word 0xDEADBEEF -> rsp_valid=01 on cycle 3, rsp_rdata=0xDEADBEEF.
// - req_valid=2'b11 held continuously after reset -> grants alternate 0,1,0,1; never two consecutive grants to one requester.
// - Req1 write addr 0x20, data 0xA5A5A5A5, bytes=4; memory write_done pulses every other cycle -> mem_write_data_valid stays high until the write_done edge; rsp_valid=10 next cycle; readback gives 0xA5A5A5A5.
// - Write bytes=2 data 0x11223344 to 0x30 over 0xFFFFFFFF -> readback 0xFFFF3344.
// - Assert rst_n=0 mid-WRITE before write_done -> mem_write_data_valid=0 immediately; no rsp_valid; state IDLE, rr_ptr=0 after release.
// - Req0 changes addr 0x40->0x44 one cycle after grant -> fetch still uses 0x40.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory port arbiter and the memory block.
package mem_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 32;
  localparam int unsigned MEM_DATA_WIDTH = 32;
  localparam int unsigned DATA_BYTE_SIZE = MEM_DATA_WIDTH / 8;
  localparam int unsigned BYTE_CNT_W     = $clog2(DATA_BYTE_SIZE) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Width of a byte-count field able to hold 0..data_width/8.
  function automatic int unsigned byte_cnt_width(input int unsigned data_width);
    return $clog2(data_width / 8) + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o
);

  int unsigned cand;

  // Scan upward from the pointer; the first hit wins.
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(ptr_i) + i) % NUM_REQ;
      if (!gnt_valid_o && req_i[IDX_W'(cand)]) begin
        gnt_valid_o             = 1'b1;
        gnt_idx_o               = IDX_W'(cand);
        gnt_o[IDX_W'(cand)]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the data memory's fetch and write ports between NUM_REQ requesters,
// one transaction at a time, with round-robin grant held to completion.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter  int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
  parameter  int unsigned NUM_REQ    = 2,
  localparam int unsigned BW         = byte_cnt_width(DATA_WIDTH)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0]                   req_we,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ-1:0][BW-1:0]           req_bytes,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [DATA_WIDTH-1:0]                rsp_rdata,
  output logic [ADDR_WIDTH-1:0]                mem_fetch_addr,
  input  logic [DATA_WIDTH-1:0]                mem_fetched_data,
  input  logic                                 mem_fetch_done,
  output logic [ADDR_WIDTH-1:0]                mem_write_addr,
  output logic [DATA_WIDTH-1:0]                mem_write_data,
  output logic [BW-1:0]                        mem_bytes_to_write,
  output logic                                 mem_write_data_valid,
  input  logic                                 mem_write_done
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e              state_q,  state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]      gnt_oh_q, gnt_oh_d;
  logic [ADDR_WIDTH-1:0]   addr_q,   addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q,  wdata_d;
  logic [BW-1:0]           bytes_q,  bytes_d;
  logic [DATA_WIDTH-1:0]   rdata_q,  rdata_d;

  logic [NUM_REQ-1:0]      arb_gnt;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (arb_gnt),
    .gnt_idx_o   (arb_idx),
    .gnt_valid_o (arb_any)
  );

  // Next-state: grant and latch in IDLE, wait on the memory, pulse response.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_oh_d = gnt_oh_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    bytes_d  = bytes_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_oh_d = arb_gnt;
          addr_d   = req_addr[arb_idx];
          wdata_d  = req_wdata[arb_idx];
          bytes_d  = req_bytes[arb_idx];
          rr_ptr_d = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          state_d  = req_we[arb_idx] ? WRITE : READ;
        end
      end
      READ: begin
        if (mem_fetch_done) begin
          rdata_d = mem_fetched_data;
          state_d = RESP;
        end
      end
      WRITE: begin
        if (mem_write_done) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_oh_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      bytes_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_oh_q <= gnt_oh_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      bytes_q  <= bytes_d;
      rdata_q  <= rdata_d;
    end
  end

  // Memory-side outputs hold the latched values; only the strobe is state-gated.
  always_comb begin
    mem_fetch_addr       = addr_q;
    mem_write_addr       = addr_q;
    mem_write_data       = wdata_q;
    mem_bytes_to_write   = bytes_q;
    mem_write_data_valid = (state_q == WRITE);
    rsp_valid            = (state_q == RESP) ? gnt_oh_q : '0;
    rsp_rdata            = rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory and a response scoreboard.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 2;
  localparam int unsigned BW = 3;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NR-1:0]             req_valid;
  logic [NR-1:0]             req_we;
  logic [NR-1:0][AW-1:0]     req_addr;
  logic [NR-1:0][DW-1:0]     req_wdata;
  logic [NR-1:0][BW-1:0]     req_bytes;
  logic [NR-1:0]             rsp_valid;
  logic [DW-1:0]             rsp_rdata;
  logic [AW-1:0]             mem_fetch_addr;
  logic [DW-1:0]             mem_fetched_data;
  logic                      mem_fetch_done;
  logic [AW-1:0]             mem_write_addr;
  logic [DW-1:0]             mem_write_data;
  logic [BW-1:0]             mem_bytes_to_write;
  logic                      mem_write_data_valid;
  logic                      mem_write_done = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [NR-1:0] oh;
    bit            rd;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .req_valid            (req_valid),
    .req_we               (req_we),
    .req_addr             (req_addr),
    .req_wdata            (req_wdata),
    .req_bytes            (req_bytes),
    .rsp_valid            (rsp_valid),
    .rsp_rdata            (rsp_rdata),
    .mem_fetch_addr       (mem_fetch_addr),
    .mem_fetched_data     (mem_fetched_data),
    .mem_fetch_done       (mem_fetch_done),
    .mem_write_addr       (mem_write_addr),
    .mem_write_data       (mem_write_data),
    .mem_bytes_to_write   (mem_bytes_to_write),
    .mem_write_data_valid (mem_write_data_valid),
    .mem_write_done       (mem_write_done)
  );

  // Behavioural memory: combinational fetch, byte-masked write on valid & done.
  logic [DW-1:0] mem [0:255];
  logic          pl_en = 1'b0;
  logic [7:0]    pl_idx = '0;
  logic [DW-1:0] pl_data = '0;
  int            wd_mode = 0;   // 0: done always high, 1: toggling, 2: held low

  assign mem_fetched_data = mem[mem_fetch_addr[9:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    if (mem_write_data_valid && mem_write_done) begin
      for (int b = 0; b < 4; b++)
        if (b < int'(mem_bytes_to_write))
          mem[mem_write_addr[9:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
    end
  end

  always @(negedge clk) begin
    case (wd_mode)
      0:       mem_write_done <= 1'b1;
      1:       mem_write_done <= ~mem_write_done;
      default: mem_write_done <= 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_idx  = a[9:2];
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic start();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit idx, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] b);
    req_we[idx]    = we;
    req_addr[idx]  = a;
    req_wdata[idx] = d;
    req_bytes[idx] = b;
    req_valid[idx] = 1'b1;
  endtask

  function automatic void push(input bit idx, input bit rd, input logic [DW-1:0] d);
    exp_t e;
    e.oh   = 2'b01 << idx;
    e.rd   = rd;
    e.data = d;
    sb.push_back(e);
  endfunction

  // Wait (bounded) for a response, then pop the scoreboard and compare.
  task automatic wait_rsp(input bit is_wr, output int lat);
    exp_t e;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rsp_valid !== '0) begin
        lat = c;
        break;
      end
      if (is_wr && c >= 2) chk("wvalid_hold", 64'(mem_write_data_valid), 64'd1);
    end
    if (lat < 0) begin
      total++;
      bad++;
      $error("FAIL rsp_timeout observed=none expected=rsp_valid within 20 cycles");
    end else if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty observed=%b expected=no response", rsp_valid);
    end else begin
      e = sb.pop_front();
      chk("rsp_onehot", 64'(rsp_valid), 64'(e.oh));
      if (e.rd) chk("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
    end
  endtask

  task automatic read_check(input bit idx, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    int lat;
    start();
    drive(idx, 1'b0, a, '0, '0);
    push(idx, 1'b1, exp);
    wait_rsp(1'b0, lat);
    req_valid = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic seen;
    rst_n          = 1'b0;
    req_valid      = '0;
    req_we         = '0;
    req_addr       = '0;
    req_wdata      = '0;
    req_bytes      = '0;
    mem_fetch_done = 1'b1;

    preload(32'h10, 32'hDEADBEEF);
    preload(32'h14, 32'h01234567);
    preload(32'h20, 32'h00000000);
    preload(32'h30, 32'hFFFFFFFF);
    preload(32'h40, 32'hCAFE0040);
    preload(32'h44, 32'hCAFE0044);
    preload(32'h50, 32'h0BADF00D);
    preload(32'h60, 32'h00000000);

    // Reset state
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rdata",     64'(rsp_rdata), 64'd0);
    chk("rst_wvalid",    64'(mem_write_data_valid), 64'd0);
    chk("rst_waddr",     64'(mem_write_addr), 64'd0);
    chk("rst_bytes",     64'(mem_bytes_to_write), 64'd0);
    rst_n = 1'b1;

    // Single read, minimum latency
    start();
    drive(1'b0, 1'b0, 32'h10, '0, '0);
    push(1'b0, 1'b1, 32'hDEADBEEF);
    wait_rsp(1'b0, lat);
    chk("read_latency", 64'(lat), 64'd3);
    req_valid = '0;

    // Both requesting continuously: grants 0,1,0,1
    do_reset();
    start();
    drive(1'b0, 1'b0, 32'h10, '0, '0);
    drive(1'b1, 1'b0, 32'h14, '0, '0);
    push(1'b0, 1'b1, 32'hDEADBEEF);
    push(1'b1, 1'b1, 32'h01234567);
    push(1'b0, 1'b1, 32'hDEADBEEF);
    push(1'b1, 1'b1, 32'h01234567);
    repeat (4) wait_rsp(1'b0, lat);
    req_valid = '0;

    // Write with toggling write_done
    wd_mode = 1;
    start();
    drive(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 3'd4);
    push(1'b1, 1'b0, '0);
    wait_rsp(1'b1, lat);
    req_valid = '0;
    chk("wr_lat_range",  64'(lat == 3 || lat == 4), 64'd1);
    chk("wr_valid_done", 64'(mem_write_data_valid), 64'd0);
    chk("wr_addr",       64'(mem_write_addr), 64'h20);
    chk("wr_data",       64'(mem_write_data), 64'hA5A5A5A5);
    chk("rdata_holds",   64'(rsp_rdata), 64'h01234567);
    wd_mode = 0;
    read_check(1'b0, 32'h20, 32'hA5A5A5A5);

    // Partial write: two bytes over all-ones
    start();
    drive(1'b0, 1'b1, 32'h30, 32'h11223344, 3'd2);
    push(1'b0, 1'b0, '0);
    wait_rsp(1'b1, lat);
    req_valid = '0;
    chk("wr2_latency", 64'(lat), 64'd3);
    read_check(1'b1, 32'h30, 32'hFFFF3344);

    // Zero-byte write completes, memory untouched
    start();
    drive(1'b1, 1'b1, 32'h30, 32'h00000000, 3'd0);
    push(1'b1, 1'b0, '0);
    wait_rsp(1'b1, lat);
    req_valid = '0;
    read_check(1'b0, 32'h30, 32'hFFFF3344);

    // Oversized byte count passes through unchanged
    start();
    drive(1'b0, 1'b1, 32'h60, 32'h55667788, 3'd5);
    push(1'b0, 1'b0, '0);
    wait_rsp(1'b1, lat);
    req_valid = '0;
    chk("bytes_passthru", 64'(mem_bytes_to_write), 64'd5);
    read_check(1'b1, 32'h60, 32'h55667788);

    // Reset in the middle of a write
    wd_mode = 2;
    start();
    drive(1'b0, 1'b1, 32'h50, 32'h12345678, 3'd4);
    repeat (2) @(negedge clk);
    chk("abort_wvalid_before", 64'(mem_write_data_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_wvalid_async", 64'(mem_write_data_valid), 64'd0);
    chk("abort_rsp",          64'(rsp_valid), 64'd0);
    req_valid = '0;
    wd_mode   = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | (|rsp_valid);
    end
    chk("abort_no_rsp", 64'(seen), 64'd0);
    // Pointer back at 0: requester 0 wins first
    start();
    drive(1'b0, 1'b0, 32'h10, '0, '0);
    drive(1'b1, 1'b0, 32'h14, '0, '0);
    push(1'b0, 1'b1, 32'hDEADBEEF);
    push(1'b1, 1'b1, 32'h01234567);
    repeat (2) wait_rsp(1'b0, lat);
    req_valid = '0;
    read_check(1'b1, 32'h50, 32'h0BADF00D);

    // Address change after grant has no effect
    start();
    drive(1'b0, 1'b0, 32'h40, '0, '0);
    push(1'b0, 1'b1, 32'hCAFE0040);
    @(posedge clk);
    #1 req_addr[0] = 32'h44;
    @(negedge clk);
    chk("latched_fetch_addr", 64'(mem_fetch_addr), 64'h40);
    wait_rsp(1'b0, lat);
    req_valid = '0;

    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
